odd_parity_serial_tx: RTL

- Transmit end of the 5-bit odd-parity link.
- Accepts a parallel DATA_W-bit word over a valid/ready handshake and computes the odd-parity bit, so the total number of ones in data plus parity is odd.
- Serialises the word as a framed bit stream on a single line: start, data LSB-first, parity, stop.
- The receiving side checks the word with the existing 5-bit odd-parity checker (E = data, P = parity).

---
 rtl/odd_parity_serial_tx.sv | 116 +++++++++++
 1 files changed

// File: rtl/odd_parity_serial_tx.sv
// Odd-parity serial transmitter: start, DATA_W data bits LSB-first, parity, stop.
// Define TX_FRAME_COUNT_EN to add the 8-bit completed-frame counter port.
module odd_parity_serial_tx #(
  parameter int DATA_W       = 5,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              tx,
  output logic              busy,
  output logic              parity_out
`ifdef TX_FRAME_COUNT_EN
  ,
  output logic [7:0]        frame_count
`endif
);

  localparam int BIT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_nxt;
  logic [7:0]        tick, tick_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0] shift, shift_nxt;
  logic              parity_nxt;
  logic              tx_nxt;
  logic              bit_end;

  function automatic logic odd_parity(input logic [DATA_W-1:0] d);
    return ~^d;
  endfunction

  assign bit_end    = (tick == 8'(CLKS_PER_BIT - 1));
  assign busy       = (state != IDLE);
  assign data_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tick       <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_out <= 1'b0;
      tx         <= 1'b1;
    end else begin
      state      <= state_nxt;
      tick       <= tick_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shift      <= shift_nxt;
      parity_out <= parity_nxt;
      tx         <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    tick_nxt    = tick;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    parity_nxt  = parity_out;

    if (state != IDLE) begin
      tick_nxt = bit_end ? 8'd0 : tick + 8'd1;
    end

    case (state)
      IDLE: begin
        if (data_valid) begin
          shift_nxt   = data_in;
          parity_nxt  = odd_parity(data_in);
          state_nxt   = START;
          tick_nxt    = 8'd0;
          bit_cnt_nxt = '0;
        end
      end
      START:  if (bit_end) state_nxt = DATA;
      DATA: begin
        if (bit_end) begin
          shift_nxt = shift >> 1;
          if (bit_cnt == BIT_W'(DATA_W - 1)) begin
            state_nxt   = PARITY;
            bit_cnt_nxt = '0;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      PARITY: if (bit_end) state_nxt = STOP;
      STOP:   if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // tx is registered, so it is driven from the state being entered
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      PARITY:  tx_nxt = parity_nxt;
      default: tx_nxt = 1'b1;
    endcase
  end

`ifdef TX_FRAME_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count <= 8'd0;
    end else if (state == STOP && bit_end) begin
      frame_count <= frame_count + 8'd1;
    end
  end
`endif

endmodule
